alu_share_arbiter: RTL and testbench

//  Shares the single combinational ALU among NUM_REQ requesters (e.g. CPU issue path, multiply, divide).

---
 rtl/alu_share_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin owner arbiter that time-shares one combinational ALU among NUM_REQ requesters.
// Optional forced release of long locks when ALU_SHARE_ARB_TIMEOUT_EN is defined.
module alu_share_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int DATA_W   = 16,
    parameter int OP_W     = 4,
    parameter int MAX_HOLD = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_op,
    input  logic [DATA_W-1:0]         alu_result,
    output logic [DATA_W-1:0]         result,
    output logic [NUM_REQ-1:0]        result_vld,
    output logic                      busy,
    output logic                      timeout_evt
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {IDLE, OWNED} state_t;

    state_t             state, state_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic [IDX_W-1:0]   rr_ptr, rr_next;
    logic [IDX_W-1:0]   owner, start, win, idx;
    logic [NUM_REQ-1:0] cand;
    logic               keep, found, timeout_hit;

`ifdef ALU_SHARE_ARB_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    logic [HOLD_W-1:0] hold_cnt;
`else
    logic unused_cfg;
    assign unused_cfg  = ^MAX_HOLD;
    assign timeout_evt = 1'b0;
`endif

    assign busy = |gnt;

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = '0;
        owner  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                alu_a  = req_a[i*DATA_W +: DATA_W];
                alu_b  = req_b[i*DATA_W +: DATA_W];
                alu_op = req_op[i*OP_W +: OP_W];
                owner  = IDX_W'(i);
            end
        end
    end

    // Decide keep/release, then arbitrate in the same edge so handoffs leave no idle cycle
    always_comb begin
        timeout_hit = 1'b0;
        keep        = (state == OWNED) && req[owner] && lock[owner];
`ifdef ALU_SHARE_ARB_TIMEOUT_EN
        if (keep && hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
            keep        = 1'b0;
            timeout_hit = 1'b1;
        end
`endif
        cand    = req;
        start   = rr_ptr;
        rr_next = rr_ptr;
        if (state == OWNED && !keep) begin
            cand[owner] = 1'b0;
            start       = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            rr_next     = start;
        end
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = int'(start) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            idx = IDX_W'(j);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        gnt_next = '0;
        if (keep)       gnt_next = gnt;
        else if (found) gnt_next[win] = 1'b1;
        state_next = (gnt_next != '0) ? OWNED : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            gnt        <= '0;
            rr_ptr     <= '0;
            result     <= '0;
            result_vld <= '0;
        end else begin
            state  <= state_next;
            gnt    <= gnt_next;
            rr_ptr <= rr_next;
            if (|gnt) begin
                result     <= alu_result;
                result_vld <= gnt;
            end else begin
                result_vld <= '0;
            end
        end
    end

`ifdef ALU_SHARE_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_cnt    <= '0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= timeout_hit;
            if (gnt_next != gnt) hold_cnt <= '0;
            else if (keep)       hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = timeout_hit;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized + directed bench for alu_share_arbiter against a behavioural owner/round-robin model.
module tb_alu_share_arbiter;
    localparam int N  = 3;
    localparam int DW = 16;
    localparam int OW = 4;
    localparam int MH = 4;
`ifdef ALU_SHARE_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock;
    logic [N*DW-1:0] req_a, req_b;
    logic [N*OW-1:0] req_op;
    logic [N-1:0]    gnt, result_vld;
    logic [DW-1:0]   alu_a, alu_b, alu_result, result;
    logic [OW-1:0]   alu_op;
    logic            busy, timeout_evt;

    int vectors = 0;
    int miscompares = 0;

    int            m_own, m_rr, m_held;
    logic [DW-1:0] m_res;
    logic [N-1:0]  m_vld;
    logic          m_tevt;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(logic [DW-1:0] a, logic [DW-1:0] b, logic [OW-1:0] op);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .gnt(gnt), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .result(result), .result_vld(result_vld),
        .busy(busy), .timeout_evt(timeout_evt)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] r, int from, int excl);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (from + k) % N;
            if (j != excl && r[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] opa(int i); return req_a[i*DW +: DW]; endfunction
    function automatic logic [DW-1:0] opb(int i); return req_b[i*DW +: DW]; endfunction
    function automatic logic [OW-1:0] opc(int i); return req_op[i*OW +: OW]; endfunction

    function automatic logic [N-1:0] exp_gnt();
        return (m_own >= 0) ? N'(1 << m_own) : '0;
    endfunction

    task automatic model_edge();
        bit stay;
        if (!rst) begin
            m_own = -1; m_rr = 0; m_held = 0; m_res = '0; m_vld = '0; m_tevt = 1'b0;
        end else begin
            if (m_own >= 0) begin
                m_res = alu_f(opa(m_own), opb(m_own), opc(m_own));
                m_vld = N'(1 << m_own);
            end else begin
                m_vld = '0;
            end
            m_tevt = 1'b0;
            if (m_own < 0) begin
                m_own  = pick(req, m_rr, -1);
                m_held = (m_own >= 0) ? 1 : 0;
            end else begin
                stay = req[m_own] && lock[m_own];
                if (TMO && stay && m_held >= MH) begin
                    stay   = 1'b0;
                    m_tevt = 1'b1;
                end
                if (stay) m_held++;
                else begin
                    m_rr   = (m_own + 1) % N;
                    m_own  = pick(req, m_rr, m_own);
                    m_held = (m_own >= 0) ? 1 : 0;
                end
            end
        end
    endtask

    task automatic check_regs();
        chk("gnt", 32'(gnt), 32'(exp_gnt()));
        chk("result_vld", 32'(result_vld), 32'(m_vld));
        chk("result", 32'(result), 32'(m_res));
        chk("timeout_evt", 32'(timeout_evt), 32'(m_tevt));
    endtask

    task automatic tick();
        #2;
        chk("alu_a", 32'(alu_a), (m_own >= 0) ? 32'(opa(m_own)) : 32'd0);
        chk("alu_b", 32'(alu_b), (m_own >= 0) ? 32'(opb(m_own)) : 32'd0);
        chk("alu_op", 32'(alu_op), (m_own >= 0) ? 32'(opc(m_own)) : 32'd0);
        chk("busy", 32'(busy), 32'(m_own >= 0));
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    initial begin
        logic [N-1:0] t2_seq [6];
        int           pulses;
        t2_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // T1: reset held with all requesting
        rst = 1'b0; req = 3'b111; lock = '0;
        req_a  = {16'd300, 16'd200, 16'd100};
        req_b  = {16'd3,   16'd2,   16'd1};
        req_op = {4'd2, 4'd1, 4'd0};
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
        for (int i = 0; i < 2; i++) tick();
        chk("t1_gnt_in_reset", 32'(gnt), 32'd0);

        // T1 release + T2 round-robin without gaps
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_rr_seq", 32'(gnt), 32'(t2_seq[i]));
        end

        // T3: requester 1 locks with ADD 3+4 while requester 0 keeps asking
        req = 3'b011; lock = 3'b010;
        req_a[1*DW +: DW] = 16'd3; req_b[1*DW +: DW] = 16'd4; req_op[1*OW +: OW] = 4'd0;
        req_a[0*DW +: DW] = 16'd50; req_b[0*DW +: DW] = 16'd9; req_op[0*OW +: OW] = 4'd1;
        for (int i = 0; i < 4 && gnt !== 3'b010; i++) tick();
        chk("t3_acquire", 32'(gnt), 32'b010);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_hold", 32'(gnt), 32'b010);
            chk("t3_result", 32'(result), 32'd7);
            chk("t3_vld", 32'(result_vld), 32'b010);
        end
        req = 3'b001; lock = '0;
        tick();
        chk("t3_handoff", 32'(gnt), 32'b001);
        chk("t3_last_vld", 32'(result_vld), 32'b010);

        // T4: nobody requesting
        req = '0;
        for (int i = 0; i < 3; i++) tick();
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_vld", 32'(result_vld), 32'd0);

        // T5: reset while requester 2 holds a lock
        req = 3'b100; lock = 3'b100;
        for (int i = 0; i < 3; i++) tick();
        chk("t5_locked", 32'(gnt), 32'b100);
        rst = 1'b0;
        tick();
        chk("t5_reset_vld", 32'(result_vld), 32'd0);
        rst = 1'b1; req = 3'b111; lock = '0;
        tick();
        chk("t5_rr_ptr_zero", 32'(gnt), 32'b001);

        // T6: requester 2 locks forever alongside requester 0
        req = 3'b101; lock = 3'b100;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (timeout_evt === 1'b1) pulses++;
        end
        chk("t6_timeout_pulses", 32'(pulses), TMO ? 32'd1 : 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 59) != 0);
            req    = N'($urandom);
            lock   = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            req_a  = {16'($urandom), 16'($urandom), 16'($urandom)};
            req_b  = {16'($urandom), 16'($urandom), 16'($urandom)};
            req_op = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
